// File: rtl/mdio_master_if.sv
// Command/response bundle between the CSR block and the MDIO controller.
// Latency: none, this only groups wires.
// Backpressure: cmd_valid/cmd_ready handshake; the response is a one-cycle pulse and cannot be stalled.
// Ports: cmd_* (request fields), rsp_* (completion pulse, read data, error flag).
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (CSR logic).
  modport master (
    output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one PHY register read/write per command.
// Latency: first bit on the accept edge, rsp_valid 128*CLK_DIV cycles after accept.
// Backpressure: cmd_ready low for the whole frame; commands offered meanwhile are ignored.
// Ports: wb_clk_i/wb_rst_i (sync active-high), csr (command/response), busy,
//        MDC/mdio_o/mdio_oe/mdio_i (pins; the tristate is built above this block).
module mdio_master #(
  parameter int CLK_DIV = 16,  // core cycles per MDC half-period, >= 2
  parameter int PRE_LEN = 32   // preamble length in bits
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  mdio_master_if.slave csr,
  output logic         busy,
  output logic         MDC,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  // Bit counter must also reach 15 for the data field.
  localparam int BW = ($clog2(PRE_LEN + 1) > 4) ? $clog2(PRE_LEN + 1) : 4;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(PRE_LEN - 1);
  localparam logic [BW-1:0] HDR_LAST = BW'(13);
  localparam logic [BW-1:0] TA_LAST  = BW'(1);
  localparam logic [BW-1:0] DAT_LAST = BW'(15);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          mdc_q, mdc_d;
  logic          mdo_q, mdo_d;
  logic          oe_q, oe_d;
  logic          wr_q, wr_d;
  logic [31:0]   sr_q, sr_d;     // ST..DATA still to be sent, MSB goes next
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          bit_end;

  // Last cycle of the MDC-high phase: the read sample point and the next bit's start.
  assign bit_end = mdc_q && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mdc_d   = mdc_q;
    mdo_d   = mdo_q;
    oe_d    = oe_q;
    wr_d    = wr_q;
    sr_d    = sr_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    // MDC free-runs only while bits are on the wire.
    if (state_q inside {PRE, HDR, TA, DATA}) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        mdc_d = ~mdc_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (csr.cmd_valid) begin
          state_d = PRE;
          div_d   = '0;
          bit_d   = '0;
          mdc_d   = 1'b0;
          mdo_d   = 1'b1;
          oe_d    = 1'b1;
          wr_d    = csr.cmd_write;
          // Read TA/DATA slots are don't-care: mdio_oe is low there.
          sr_d    = {2'b01, (csr.cmd_write ? 2'b01 : 2'b10), csr.cmd_phy_addr,
                     csr.cmd_reg_addr, (csr.cmd_write ? 2'b10 : 2'b11),
                     (csr.cmd_write ? csr.cmd_wdata : 16'hFFFF)};
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      PRE: begin
        if (bit_end) begin
          if (bit_q == PRE_LAST) begin
            state_d = HDR;
            bit_d   = '0;
            mdo_d   = sr_q[31];
            sr_d    = {sr_q[30:0], 1'b0};
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      HDR: begin
        if (bit_end) begin
          mdo_d = sr_q[31];
          sr_d  = {sr_q[30:0], 1'b0};
          if (bit_q == HDR_LAST) begin
            state_d = TA;
            bit_d   = '0;
            oe_d    = wr_q;   // reads release the line from TA onwards
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      TA: begin
        if (bit_end) begin
          mdo_d = sr_q[31];
          sr_d  = {sr_q[30:0], 1'b0};
          if (bit_q == TA_LAST) begin
            // A PHY that answers pulls the second TA bit low.
            if (!wr_q) err_d = mdio_i;
            state_d = DATA;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (!wr_q) rdata_d = {rdata_q[14:0], mdio_i};
          if (bit_q == DAT_LAST) begin
            state_d = DONE;
            bit_d   = '0;
            oe_d    = 1'b0;
            mdo_d   = 1'b1;
          end else begin
            mdo_d = sr_q[31];
            sr_d  = {sr_q[30:0], 1'b0};
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      mdc_q   <= 1'b0;
      mdo_q   <= 1'b1;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      sr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mdc_q   <= mdc_d;
      mdo_q   <= mdo_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      sr_q    <= sr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign csr.cmd_ready = ~busy;
  assign csr.rsp_valid = (state_q == DONE);
  assign csr.rsp_rdata = rdata_q;
  assign csr.rsp_err   = err_q;
  assign MDC           = mdc_q;
  assign mdio_o        = mdo_q;
  assign mdio_oe       = oe_q;

endmodule
